// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the fetch/data bus arbiter: bus widths, FSM state
// encoding and the last-grant marker.
package bus_arbiter_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned SEL_W  = DATA_W / 8;

  typedef enum logic [1:0] {
    ArbIdle  = 2'd0,
    ArbBusyI = 2'd1,
    ArbBusyD = 2'd2
  } arb_state_t;

  typedef enum logic {
    GrantI = 1'b0,
    GrantD = 1'b1
  } grant_t;

endpackage

// File: rtl/bus_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-port memory with
// alternating priority on contention and a per-transaction timeout.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [SEL_W-1:0]  d_sel,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              d_err,
  output logic              s_req,
  output logic              s_we,
  output logic [SEL_W-1:0]  s_sel,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_ack,
  output logic              stallreq
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  arb_state_t state, state_next;
  grant_t     last_grant;
  logic [7:0] to_cnt;
  logic       i_pend, d_pend;
  logic       grant_i, grant_d;
  logic       done, expire;

  // A port is masked during its own ack cycle.
  assign i_pend   = i_req & ~i_ack;
  assign d_pend   = d_req & ~d_ack;
  assign stallreq = i_pend | d_pend;
  assign s_req    = (state != ArbIdle);

  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    done       = 1'b0;
    expire     = 1'b0;
    unique case (state)
      ArbIdle: begin
        if (i_pend && d_pend) begin
          grant_d = (last_grant == GrantI);
          grant_i = (last_grant == GrantD);
        end else begin
          grant_i = i_pend;
          grant_d = d_pend;
        end
        if (grant_i)      state_next = ArbBusyI;
        else if (grant_d) state_next = ArbBusyD;
      end
      ArbBusyI, ArbBusyD: begin
        if (s_ack) begin
          done       = 1'b1;
          state_next = ArbIdle;
        end else if (to_cnt == TO_LAST) begin
          expire     = 1'b1;
          state_next = ArbIdle;
        end
      end
      default: state_next = ArbIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ArbIdle;
      last_grant <= GrantI;
      to_cnt     <= '0;
      s_we       <= 1'b0;
      s_sel      <= '0;
      s_addr     <= '0;
      s_wdata    <= '0;
      i_ack      <= 1'b0;
      i_err      <= 1'b0;
      i_rdata    <= '0;
      d_ack      <= 1'b0;
      d_err      <= 1'b0;
      d_rdata    <= '0;
    end else begin
      state <= state_next;
      i_ack <= 1'b0;
      i_err <= 1'b0;
      d_ack <= 1'b0;
      d_err <= 1'b0;

      if (grant_i) begin
        s_we    <= 1'b0;
        s_sel   <= '1;
        s_addr  <= i_addr;
        s_wdata <= '0;
      end
      if (grant_d) begin
        s_we    <= d_we;
        s_sel   <= d_sel;
        s_addr  <= d_addr;
        s_wdata <= d_wdata;
      end

      if (grant_i || grant_d)
        to_cnt <= '0;
      else if (state != ArbIdle && !done && !expire)
        to_cnt <= to_cnt + 8'd1;

      // Completion and timeout share one path; expire implies no s_ack.
      if (done || expire) begin
        if (state == ArbBusyI) begin
          i_ack      <= 1'b1;
          i_err      <= expire;
          i_rdata    <= expire ? '0 : s_rdata;
          last_grant <= GrantI;
        end else begin
          d_ack      <= 1'b1;
          d_err      <= expire;
          d_rdata    <= expire ? '0 : s_rdata;
          last_grant <= GrantD;
        end
      end
    end
  end

endmodule
